// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Issue and result handshake bundle for the multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Radix-2 iterative RV32M multiply/divide unit, one op in flight.
//               Optional macro MULDIV_EARLY_OUT_EN: trivial ops finish in 1 cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    input  wire logic    flush,
    muldiv_unit_if.slave io,
    output logic         busy
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [2:0]       op_q,       op_d;
    logic [XLEN-1:0]  hi_q,       hi_d;
    logic [XLEN-1:0]  lo_q,       lo_d;
    logic [XLEN-1:0]  m_q,        m_d;
    logic             neg_q,      neg_d;
    logic             rneg_q,     rneg_d;
    logic             spec_q,     spec_d;
    logic [XLEN-1:0]  spec_val_q, spec_val_d;
    logic [XLEN-1:0]  result_q,   result_d;
    logic [TAG_W-1:0] tag_q,      tag_d;

    // Results that are fixed by the operands alone: {hit, value}.
    function automatic logic [XLEN:0] special_case(input logic [2:0]      op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        logic [XLEN:0] r;
        r = {1'b0, {XLEN{1'b0}}};
        if (op[2]) begin
            if (b == {XLEN{1'b0}})
                r = {1'b1, (op[1] ? a : ALL_ONES)};
            else if (!op[0] && (a == MIN_VAL) && (b == ALL_ONES))
                r = {1'b1, (op[1] ? {XLEN{1'b0}} : a)};
            else if (a == {XLEN{1'b0}})
                r = {1'b1, {XLEN{1'b0}}};
        end else if ((a == {XLEN{1'b0}}) || (b == {XLEN{1'b0}})) begin
            r = {1'b1, {XLEN{1'b0}}};
        end
        return r;
    endfunction

    // ---------------- operand conditioning at issue ----------------
    logic            in_sa, in_sb, in_an, in_bn;
    logic [XLEN-1:0] in_mag_a, in_mag_b;
    logic [XLEN:0]   in_spec;

    always_comb begin
        in_sa    = (io.in_op == 3'b001) || (io.in_op == 3'b010) ||
                   (io.in_op == 3'b100) || (io.in_op == 3'b110);
        in_sb    = (io.in_op == 3'b001) || (io.in_op == 3'b100) ||
                   (io.in_op == 3'b110);
        in_an    = in_sa && io.in_a[XLEN-1];
        in_bn    = in_sb && io.in_b[XLEN-1];
        in_mag_a = in_an ? (~io.in_a + 1'b1) : io.in_a;
        in_mag_b = in_bn ? (~io.in_b + 1'b1) : io.in_b;
        in_spec  = special_case(io.in_op, io.in_a, io.in_b);
    end

    // ---------------- one radix-2 iteration ----------------
    // Multiply: {hi,lo} shifts right, multiplicand m added when lo[0] is set.
    // Divide: dividend leaves lo from the top, quotient bits enter at the bottom.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? m_q : {XLEN{1'b0}})};
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, m_q});
        div_diff  = div_shift[XLEN-1:0] - m_q;
        if (op_q[2]) begin
            step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ---------------- sign fix-up and result selection ----------------
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_result;

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q  ? (~prod    + 1'b1) : prod;
        quot_fix = neg_q  ? (~step_lo + 1'b1) : step_lo;
        rem_fix  = rneg_q ? (~step_hi + 1'b1) : step_hi;
        case (op_q)
            3'b000:                 fix_result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_result = quot_fix;
            default:                fix_result = rem_fix;
        endcase
        if (spec_q)
            fix_result = spec_val_q;
    end

    // ---------------- control ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        m_d        = m_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        result_d   = result_q;
        tag_d      = tag_q;

        case (state_q)
            S_IDLE: begin
                if (io.in_valid && !flush) begin
                    op_d       = io.in_op;
                    tag_d      = io.in_tag;
                    hi_d       = {XLEN{1'b0}};
                    m_d        = io.in_op[2] ? in_mag_b : in_mag_a;
                    lo_d       = io.in_op[2] ? in_mag_a : in_mag_b;
                    neg_d      = in_an ^ in_bn;
                    rneg_d     = in_an;
                    spec_d     = in_spec[XLEN];
                    spec_val_d = in_spec[XLEN-1:0];
                    cnt_d      = CNT_W'(XLEN-1);
`ifdef MULDIV_EARLY_OUT_EN
                    if (in_spec[XLEN]) begin
                        result_d = in_spec[XLEN-1:0];
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
`else
                    state_d    = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                hi_d = step_hi;
                lo_d = step_lo;
                if (cnt_q == {CNT_W{1'b0}}) begin
                    result_d = fix_result;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (io.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A squash overrides completion and delivery alike.
        if (flush)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            op_q       <= 3'b000;
            hi_q       <= {XLEN{1'b0}};
            lo_q       <= {XLEN{1'b0}};
            m_q        <= {XLEN{1'b0}};
            neg_q      <= 1'b0;
            rneg_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= {XLEN{1'b0}};
            result_q   <= {XLEN{1'b0}};
            tag_q      <= {TAG_W{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            m_q        <= m_d;
            neg_q      <= neg_d;
            rneg_q     <= rneg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            result_q   <= result_d;
            tag_q      <= tag_d;
        end
    end

    assign io.in_ready   = (state_q == S_IDLE);
    assign io.out_valid  = (state_q == S_DONE);
    assign io.out_result = result_q;
    assign io.out_tag    = tag_q;
    assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit (default build, no early out).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int LAT   = XLEN + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic busy;

    muldiv_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic             exp_pending = 1'b0;
    logic [XLEN-1:0]  exp_result  = '0;
    logic [TAG_W-1:0] exp_tag     = '0;
    logic             prev_hold   = 1'b0;
    logic [XLEN-1:0]  prev_result = '0;
    logic [TAG_W-1:0] prev_tag    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'b000: r = ua * ub;
            3'b001: r = (sa * sb) >>> 32;
            3'b010: r = (sa * ub) >>> 32;
            3'b011: r = (ua * ub) >> 32;
            3'b100: r = (b == 0) ? -1 : ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? sa : sa / sb);
            3'b101: r = (b == 0) ? -1 : ua / ub;
            3'b110: r = (b == 0) ? sa : ((a == 32'h80000000 && b == 32'hFFFFFFFF) ? 0 : sa % sb);
            default: r = (b == 0) ? ua : ua % ub;
        endcase
        return r[31:0];
    endfunction

    // Output monitor: every cycle a result is shown it must be the expected one and held.
    always @(negedge clk) begin
        #2;
        if (rst_n && bus.out_valid) begin
            check("out_valid_expected", exp_pending, 1);
            check("out_result", bus.out_result, exp_result);
            check("out_tag", bus.out_tag, exp_tag);
            check("in_ready_in_done", bus.in_ready, 0);
            if (prev_hold) begin
                check("result_stable", bus.out_result, prev_result);
                check("tag_stable", bus.out_tag, prev_tag);
            end
        end
        prev_hold   = rst_n && bus.out_valid && !bus.out_ready;
        prev_result = bus.out_result;
        prev_tag    = bus.out_tag;
    end

    // Called at a negedge; presents the op and waits for it to be accepted.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp);
        int n;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_issue", bus.in_ready, 1);
        exp_result   = exp;
        exp_tag      = tag;
        exp_pending  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_tag   = TAG_W'($urandom);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input logic [31:0] exp, input int hold);
        int n;
        issue(op, a, b, tag, exp);
        n = 1;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, LAT);
        repeat (hold) @(negedge clk);
        check("in_ready_low_while_holding", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        exp_pending   = 1'b0;
        check("out_valid_after_accept", bus.out_valid, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return $urandom_range(0, 20);
            4:       return -$urandom_range(1, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [4:0]  tag;

        bus.in_valid  = 1'b0;
        bus.in_op     = 3'b000;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_result", bus.out_result, 0);
        check("reset_out_tag", bus.out_tag, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with hand-derived results.
        run_op(3'b000, 32'd7,        32'hFFFFFFFD, 5'd4,  32'hFFFFFFEB, 0);
        run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 5);
        run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000, 1);
        run_op(3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 0);
        run_op(3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 0);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 2);
        run_op(3'b101, 32'h80000000, 32'd0,        5'd7,  32'hFFFFFFFF, 0);
        run_op(3'b111, 32'h80000000, 32'd0,        5'd8,  32'h80000000, 0);
        run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd9,  32'h80000000, 0);
        run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h00000000, 3);

        // Flush in the tenth busy cycle: nothing may be delivered.
        issue(3'b000, 32'd1234, 32'd5678, 5'd11, 32'd0);
        repeat (9) @(negedge clk);
        flush       = 1'b1;
        exp_pending = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", bus.in_ready, 1);
        check("flush_out_valid", bus.out_valid, 0);
        check("flush_busy", busy, 0);
        repeat (LAT + 4) @(negedge clk);
        run_op(3'b000, 32'd100, 32'd3, 5'd12, 32'd300, 0);

        // Flush together with an issue request in IDLE: not accepted.
        bus.in_valid = 1'b1;
        bus.in_op    = 3'b101;
        bus.in_a     = 32'd9;
        bus.in_b     = 32'd3;
        flush        = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        flush        = 1'b0;
        check("flush_idle_busy", busy, 0);
        check("flush_idle_in_ready", bus.in_ready, 1);
        repeat (LAT + 4) @(negedge clk);

        // Asynchronous reset in the middle of an operation.
        issue(3'b101, 32'd1000, 32'd7, 5'd13, 32'd142);
        repeat (5) @(negedge clk);
        exp_pending = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("midreset_in_ready", bus.in_ready, 1);
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_out_result", bus.out_result, 0);
        check("midreset_out_tag", bus.out_tag, 0);
        check("midreset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3'b101, 32'd1000, 32'd7, 5'd14, 32'd142, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 80; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            tag = 5'($urandom);
            run_op(op, a, b, tag, model(op, a, b), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
